// File: rtl/shift_exec_unit.sv
// shift_exec_unit: regfile sequencer feeding an external shift-left stage and writing back its result
module shift_exec_unit #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [4:0]    cmd_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic [31:0]   shf_rin,
    output logic [4:0]    shf_n,
    input  logic [31:0]   shf_rx,
    output logic          done,
    output logic [AW-1:0] done_dst
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WRITE} state_t;

    state_t        state;
    logic [31:0]   regs [NREG];
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [4:0]    n;
    logic [31:0]   result;

    assign rd_data = regs[rd_addr];

    // Command sequencer: latch, fetch operand, capture shifter result, write back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            src       <= '0;
            dst       <= '0;
            n         <= '0;
            result    <= '0;
            shf_rin   <= '0;
            shf_n     <= '0;
            done      <= 1'b0;
            done_dst  <= '0;
            cmd_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) regs[wr_addr] <= wr_data;
                    if (cmd_valid) begin
                        src       <= cmd_src;
                        dst       <= cmd_dst;
                        n         <= cmd_n;
                        cmd_ready <= 1'b0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    shf_rin <= regs[src];
                    shf_n   <= n;
                    state   <= EXEC;
                end
                EXEC: begin
                    result   <= shf_rx;
                    done     <= 1'b1;
                    done_dst <= dst;
                    state    <= WRITE;
                end
                WRITE: begin
                    regs[dst] <= result;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_exec_unit.sv
// tb_shift_exec_unit: directed and random checks of shift_exec_unit against a command-level model
module tb_shift_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_src, cmd_dst;
    logic [4:0]  cmd_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] shf_rin;
    logic [4:0]  shf_n;
    logic [31:0] shf_rx;
    logic        done;
    logic [2:0]  done_dst;

    int checks = 0;
    int failures = 0;

    shift_exec_unit #(.NREG(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_n(cmd_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .shf_rin(shf_rin), .shf_n(shf_n), .shf_rx(shf_rx),
        .done(done), .done_dst(done_dst)
    );

    // the external combinational shifter stage
    assign shf_rx = shf_rin << shf_n;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Command-level model: on accept the whole outcome is computed; timing follows edges since accept
    logic [31:0] mreg [8];
    bit          busy;
    int          age;
    int          cyc = 0;
    int          last_done = 0;
    int          prev_done = 0;
    logic [31:0] p_val, p_res, e_rin;
    logic [4:0]  p_n, e_n;
    logic [2:0]  p_dst, e_dd;
    bit          e_done;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            busy = 0;
            age = 0;
            foreach (mreg[i]) mreg[i] = '0;
            e_rin = '0;
            e_n = '0;
            e_dd = '0;
        end else if (busy) begin
            age++;
            if (age == 1) begin
                e_rin = p_val;
                e_n = p_n;
            end
            if (age == 3) begin
                mreg[p_dst] = p_res;
                busy = 0;
            end
        end else begin
            if (wr_en) mreg[wr_addr] = wr_data;
            if (cmd_valid) begin
                busy = 1;
                age = 0;
                p_val = mreg[cmd_src];
                p_n = cmd_n;
                p_res = p_val << cmd_n;
                p_dst = cmd_dst;
            end
        end
        e_done = busy && age == 2;
        if (e_done) e_dd = p_dst;
        #2;
        chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, !busy});
        chk("done", {31'b0, done}, {31'b0, e_done});
        if (e_done) chk("done_dst", {29'b0, done_dst}, {29'b0, e_dd});
        chk("shf_rin", shf_rin, e_rin);
        chk("shf_n", {27'b0, shf_n}, {27'b0, e_n});
        chk("rd_data", rd_data, mreg[rd_addr]);
        if (done) begin
            prev_done = last_done;
            last_done = cyc;
        end
    end

    task automatic load(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL wait_ready actual=0 required=1 at %0t", $time);
        end
    endtask

    task automatic issue(input logic [2:0] s, input logic [2:0] d, input logic [4:0] sh, output int lowcnt);
        @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_src = s;
        cmd_dst = d;
        cmd_n = sh;
        lowcnt = 0;
        repeat (4) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_src = ~s;
            if (!cmd_ready) lowcnt++;
        end
    endtask

    task automatic peek(input logic [2:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_en = 1'b0;
        rd_addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    initial begin
        int lc;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_src = '0;
        cmd_dst = '0;
        cmd_n = '0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (2) @(negedge clk);
        chk("reset_shf_rin", shf_rin, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_ready", {31'b0, cmd_ready}, 32'h1);
        rst_n = 1'b1;

        load(3'd1, 32'h0000_0001);
        issue(3'd1, 3'd2, 5'd31, lc);
        peek(3'd2, 32'h8000_0000, "t1_r2");
        peek(3'd1, 32'h0000_0001, "t1_r1");

        load(3'd3, 32'hFFFF_FFFF);
        issue(3'd3, 3'd3, 5'd4, lc);
        chk("t2_ready_low_cycles", lc, 3);
        peek(3'd3, 32'hFFFF_FFF0, "t2_r3");

        load(3'd5, 32'h1234_5678);
        issue(3'd5, 3'd6, 5'd0, lc);
        peek(3'd6, 32'h1234_5678, "t3_copy");

        @(negedge clk);
        wait_ready();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h0000_00FF;
        cmd_valid = 1'b1; cmd_src = 3'd1; cmd_dst = 3'd0; cmd_n = 5'd8;
        @(negedge clk);
        wr_en = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        peek(3'd0, 32'h0000_FF00, "t4_r0");
        peek(3'd1, 32'h0000_00FF, "t4_r1");

        load(3'd1, 32'd3);
        @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1; cmd_src = 3'd1; cmd_dst = 3'd2; cmd_n = 5'd1;
        @(negedge clk);
        cmd_src = 3'd2; cmd_dst = 3'd4;
        repeat (3) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        peek(3'd2, 32'd6, "t5_r2");
        peek(3'd4, 32'd12, "t5_r4");
        chk("t5_done_gap", last_done - prev_done, 4);

        @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1; cmd_src = 3'd1; cmd_dst = 3'd7; cmd_n = 5'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_done", {31'b0, done}, 32'h0);
        chk("t6_shf_rin", shf_rin, 32'h0);
        chk("t6_shf_n", {27'b0, shf_n}, 32'h0);
        chk("t6_done_dst", {29'b0, done_dst}, 32'h0);
        chk("t6_ready", {31'b0, cmd_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        peek(3'd7, 32'h0, "t6_r7");
        peek(3'd1, 32'h0, "t6_r1");

        repeat (400) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 9) < 4);
            cmd_src = 3'($urandom);
            cmd_dst = 3'($urandom);
            cmd_n = 5'($urandom);
            wr_en = ($urandom_range(0, 9) < 4);
            wr_addr = 3'($urandom);
            wr_data = $urandom;
            rd_addr = 3'($urandom);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_en = 1'b0;
        repeat (6) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/shift_exec_unit.md
# shift_exec_unit

Sequencer that sits directly upstream and downstream of the ALU's combinational 32-bit logical-shift-left stage. It owns a small 32-bit register file, fetches the source operand and shift amount, and presents them to the shifter from registered outputs. It then captures the shifted result and writes it back to a destination register, with a valid/ready command handshake and a done pulse.

## Interface
- NREG, 8, number of 32-bit registers in the file (power of two)
- AW, 3, register address width, log2(NREG)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  shift command present
- cmd_ready  out  1  unit can accept a command (high only in IDLE)
- cmd_src  in  AW  source register index
- cmd_dst  in  AW  destination register index
- cmd_n  in  5  shift amount, 0..31
- wr_en  in  1  host register load strobe
- wr_addr  in  AW  host load index
- wr_data  in  32  host load value
- rd_addr  in  AW  debug read index
- rd_data  out  32  combinational read, regfile[rd_addr]
- shf_rin  out  32  registered operand to the shifter
- shf_n  out  5  registered shift amount to the shifter
- shf_rx  in  32  shifter result (combinational from shf_rin/shf_n)
- done  out  1  one-cycle pulse on the writeback cycle
- done_dst  out  AW  destination index written; valid when done=1

## Operation
- States: IDLE, FETCH, EXEC, WRITE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_src, cmd_dst and cmd_n into internal registers and go to FETCH.
- FETCH:
  - shf_rin <= regfile[src]; shf_n <= n.
  - Go to EXEC.
- EXEC:
  - Shifter output settles combinationally.
  - result <= shf_rx; go to WRITE.
- WRITE:
  - regfile[dst] <= result; done=1; done_dst=dst.
  - Go to IDLE.
- Arithmetic is defined by the shifter: result = shf_rin << shf_n, truncated to 32 bits, zero fill.
  - n=0 gives an unmodified copy.
  - This unit does no arithmetic of its own.
- src==dst is legal: the register is overwritten with its shifted value.
- Host loads (wr_en) are performed only in IDLE. wr_en in FETCH/EXEC/WRITE is ignored and has no side effect.
- Same-cycle wr_en and command accept in IDLE:
  - The host write is performed and the command is accepted.
  - The FETCH read in the next cycle sees the new value, including when wr_addr==cmd_src.
- cmd_src/cmd_dst/cmd_n changing after accept have no effect on the command in flight.
- rd_data always reflects the current regfile contents, including writeback from the preceding edge.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all registers = 0.
  - shf_rin=0, shf_n=0, done=0, done_dst=0, cmd_ready=1 once in IDLE.
- Reset asserted mid-operation aborts the command: no writeback and no done pulse.
- Handshake: a command is accepted at the rising edge where cmd_valid=1 and cmd_ready=1.
- Edge numbering, counting the accept edge as edge 0:
  - edge 1: shf_rin/shf_n valid.
  - edge 2: result captured.
  - edge 3: register written.
  - done=1 during the cycle after edge 2, i.e. the WRITE state.
  - cmd_ready returns high after edge 3.
- Throughput: one command per 4 cycles. Back-to-back commands are accepted on consecutive IDLE cycles.
- A dependent next command reading the previous dst sees the written value, since its FETCH is at least 2 edges after the write.
- done is a Moore output of WRITE: exactly one cycle per command, never asserted twice.

## Test plan
- Reset, then load r1=0x0000_0001 and cmd src=1, dst=2, n=31 -> done after 3 edges, done_dst=2, rd_data(r2)=0x8000_0000, r1 unchanged.
- Load r3=0xFFFF_FFFF; cmd src=3, dst=3, n=4 -> r3=0xFFFF_FFF0; cmd_ready low for exactly 3 cycles after accept.
- cmd src=5, dst=6, n=0 with r5=0x1234_5678 -> r6=0x1234_5678 (copy path).
- Same-cycle wr_en (addr=1, data=0x0000_00FF) with cmd src=1, dst=0, n=8 -> r0=0x0000_FF00. Then wr_en to r0 during EXEC is ignored: r0 stays 0x0000_FF00.
- Two back-to-back commands, cmd_valid held high: r1<<1 into r2, then r2<<1 into r4, with r1=3 -> r2=6, r4=12, done pulses exactly 4 cycles apart.
- rst_n pulsed low during EXEC -> no done, destination unchanged (0 after reset), all outputs 0, cmd_ready=1 on the first edge after release.
